result_broadcast: RTL and testbench

RESULT_BROADCAST -- requirements
Module: result_broadcast

---
 rtl/result_broadcast.sv | 113 +++++++++++
 tb/tb_result_broadcast.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/result_broadcast.sv
// Result broadcast stage: queues completed execute results, broadcasts the oldest one
// per cycle to the issue queue and ROB, and tracks per-physical-register availability.
module result_broadcast (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        exe_result_valid,
    input  logic [5:0]  exe_result_map,
    input  logic [31:0] exe_result_val,
    input  logic [31:0] exe_result_instr_num,
    output logic        exe_result_ready,
    input  logic        rename_alloc,
    input  logic [5:0]  rename_alloc_map,
    output logic        exe_broadcast,
    output logic [5:0]  exe_broadcast_map,
    output logic [31:0] exe_broadcast_val,
    output logic [31:0] exe_broadcast_instr_num,
    output logic [63:0] busy,
    output logic [2:0]  pending_count
);

    localparam int unsigned MAP_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned NREG   = 64;

    typedef struct packed {
        logic [MAP_W-1:0]  map;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] num;
    } entry_t;

    entry_t             r_fifo [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    entry_t             r_bc;
    logic               r_bc_valid;
    logic [NREG-1:0]    r_busy;

    entry_t             w_in;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    entry_t             w_next_bc;
    logic               w_next_bc_valid;
    logic [NREG-1:0]    w_busy_next;

    // A slot freed by this cycle's pop is deliberately not offered to the producer.
    assign exe_result_ready = (r_count < CNT_W'(DEPTH)) && !STALL && !FLUSH;

    assign w_in     = '{map: exe_result_map, val: exe_result_val, num: exe_result_instr_num};
    assign w_accept = exe_result_valid && exe_result_ready;
    assign w_pop    = (r_count != '0);
    assign w_push   = w_accept && w_pop;

    // Oldest pending result wins; an accepted result into an empty FIFO bypasses it.
    always_comb begin
        w_next_bc       = '0;
        w_next_bc_valid = 1'b0;
        if (w_pop) begin
            w_next_bc       = r_fifo[r_rd_ptr];
            w_next_bc_valid = 1'b1;
        end else if (w_accept) begin
            w_next_bc       = w_in;
            w_next_bc_valid = 1'b1;
        end
    end

    // Allocation clears, broadcast sets (set wins); register 0 is hardwired available.
    always_comb begin
        w_busy_next = r_busy;
        if (rename_alloc && (rename_alloc_map != '0))
            w_busy_next[rename_alloc_map] = 1'b0;
        if (w_next_bc_valid && (w_next_bc.map != '0))
            w_busy_next[w_next_bc.map] = 1'b1;
        w_busy_next[0] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_in;
    end

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_bc       <= '0;
            r_bc_valid <= 1'b0;
            r_busy     <= '1;
        end else if (!STALL) begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_bc       <= w_next_bc;
            r_bc_valid <= w_next_bc_valid;
            r_busy     <= w_busy_next;
        end
    end

    assign exe_broadcast           = r_bc_valid;
    assign exe_broadcast_map       = r_bc.map;
    assign exe_broadcast_val       = r_bc.val;
    assign exe_broadcast_instr_num = r_bc.num;
    assign busy                    = r_busy;
    assign pending_count           = r_count;

endmodule

// File: tb/tb_result_broadcast.sv
// Scoreboard bench for result_broadcast: accepted results are queued as expectations
// and compared against the broadcast port at every clock edge.
module tb_result_broadcast;

    logic        CLK = 1'b0;
    logic        RESET, STALL, FLUSH;
    logic        exe_result_valid;
    logic [5:0]  exe_result_map;
    logic [31:0] exe_result_val, exe_result_instr_num;
    logic        exe_result_ready;
    logic        rename_alloc;
    logic [5:0]  rename_alloc_map;
    logic        exe_broadcast;
    logic [5:0]  exe_broadcast_map;
    logic [31:0] exe_broadcast_val, exe_broadcast_instr_num;
    logic [63:0] busy;
    logic [2:0]  pending_count;

    result_broadcast dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .exe_result_valid(exe_result_valid), .exe_result_map(exe_result_map),
        .exe_result_val(exe_result_val), .exe_result_instr_num(exe_result_instr_num),
        .exe_result_ready(exe_result_ready),
        .rename_alloc(rename_alloc), .rename_alloc_map(rename_alloc_map),
        .exe_broadcast(exe_broadcast), .exe_broadcast_map(exe_broadcast_map),
        .exe_broadcast_val(exe_broadcast_val), .exe_broadcast_instr_num(exe_broadcast_instr_num),
        .busy(busy), .pending_count(pending_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        bit [5:0]  map;
        bit [31:0] val;
        bit [31:0] num;
    } res_t;

    res_t      q[$];
    res_t      m_bc;
    bit        m_bcv;
    bit [63:0] m_busy;
    int        n_vec = 0;
    int        n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, check ready, advance the reference model, check outputs.
    task automatic step(input bit v, input bit [5:0] m, input bit [31:0] val, input bit [31:0] num,
                        input bit al, input bit [5:0] am, input bit st, input bit fl, input bit rs,
                        output bit acc);
        bit exp_rdy;
        exe_result_valid = v; exe_result_map = m; exe_result_val = val; exe_result_instr_num = num;
        rename_alloc = al; rename_alloc_map = am; STALL = st; FLUSH = fl; RESET = rs;
        #1;
        exp_rdy = (q.size() < 4) && !st && !fl;
        check_eq("ready", 64'(exe_result_ready), 64'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge CLK);
        if (rs || fl) begin
            q.delete();
            m_bc = '0; m_bcv = 1'b0; m_busy = '1;
        end else if (!st) begin
            if (acc) q.push_back('{map: m, val: val, num: num});
            if (q.size() > 0) begin
                m_bc = q.pop_front(); m_bcv = 1'b1;
            end else begin
                m_bc = '0; m_bcv = 1'b0;
            end
            if (al && am != 6'd0) m_busy[am] = 1'b0;
            if (m_bcv && m_bc.map != 6'd0) m_busy[m_bc.map] = 1'b1;
        end
        #1;
        check_eq("bcast_valid", 64'(exe_broadcast), 64'(m_bcv));
        check_eq("bcast_map", 64'(exe_broadcast_map), 64'(m_bc.map));
        check_eq("bcast_val", 64'(exe_broadcast_val), 64'(m_bc.val));
        check_eq("bcast_num", 64'(exe_broadcast_instr_num), 64'(m_bc.num));
        check_eq("busy", busy, m_busy);
        check_eq("pending_count", 64'(pending_count), 64'(q.size()));
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    initial begin
        bit        a;
        bit        hv;
        bit [5:0]  hm;
        bit [31:0] hval, hnum;
        bit        st, fl, rs, al;
        bit [5:0]  am;
        int        seq;

        RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
        exe_result_valid = 1'b0; exe_result_map = '0; exe_result_val = '0; exe_result_instr_num = '0;
        rename_alloc = 1'b0; rename_alloc_map = '0;
        m_bc = '0; m_bcv = 1'b0; m_busy = '1;
        @(posedge CLK); #1;

        // reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
        check_eq("reset_busy_all_ones", busy, 64'hFFFF_FFFF_FFFF_FFFF);

        // bypass: map 5
        step(0, 0, 0, 0, 1, 6'd5, 0, 0, 0, a);
        check_eq("alloc5_busy", 64'(busy[5]), 64'd0);
        step(1, 6'd5, 32'hDEADBEEF, 32'd7, 0, 0, 0, 0, 0, a);
        check_eq("bypass_valid", 64'(exe_broadcast), 64'd1);
        check_eq("bypass_busy5", 64'(busy[5]), 64'd1);
        idle(1);

        // scoreboard on map 9, then same-edge alloc and broadcast
        step(0, 0, 0, 0, 1, 6'd9, 0, 0, 0, a);
        check_eq("alloc9_busy", 64'(busy[9]), 64'd0);
        idle(2);
        step(1, 6'd9, 32'h1111_2222, 32'd20, 0, 0, 0, 0, 0, a);
        check_eq("bcast9_busy", 64'(busy[9]), 64'd1);
        step(1, 6'd9, 32'h3333_4444, 32'd21, 1, 6'd9, 0, 0, 0, a);
        check_eq("set_wins_busy9", 64'(busy[9]), 64'd1);

        // map 0
        step(0, 0, 0, 0, 1, 6'd0, 0, 0, 0, a);
        check_eq("alloc0_busy0", 64'(busy[0]), 64'd1);
        step(1, 6'd0, 32'hABCD, 32'd3, 0, 0, 0, 0, 0, a);
        check_eq("map0_num", 64'(exe_broadcast_instr_num), 64'd3);

        // stall holds everything, producer holds its result, then a burst of six
        step(1, 6'd33, 32'h5555, 32'd40, 1, 6'd34, 0, 0, 0, a);
        for (int i = 0; i < 3; i++) step(1, 6'd35, 32'h6666, 32'd41, 1, 6'd36, 1, 0, 0, a);
        for (int i = 0; i < 6; i++) step(1, 6'(40 + i), 32'(i * 7 + 1), 32'(41 + i), 0, 0, 0, 0, 0, a);
        idle(2);

        // flush with busy[12] pending and a result on the input
        step(0, 0, 0, 0, 1, 6'd12, 0, 0, 0, a);
        step(1, 6'd13, 32'h77, 32'd50, 0, 0, 0, 0, 0, a);
        step(1, 6'd14, 32'h88, 32'd51, 0, 0, 0, 1, 0, a);
        check_eq("flush_bcast", 64'(exe_broadcast), 64'd0);
        check_eq("flush_busy", busy, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);

        // reset while stalled
        step(0, 0, 0, 0, 1, 6'd20, 0, 0, 0, a);
        step(1, 6'd21, 32'h99, 32'd60, 0, 0, 0, 0, 0, a);
        step(1, 6'd22, 32'hAA, 32'd61, 0, 0, 1, 0, 1, a);
        check_eq("reset_stall_busy", busy, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);

        // random traffic with a holding producer
        hv = 0; hm = '0; hval = '0; hnum = '0; seq = 100;
        for (int i = 0; i < 400; i++) begin
            if (!hv && $urandom_range(0, 3) != 0) begin
                hv = 1; hm = 6'($urandom); hval = $urandom; hnum = 32'(seq); seq++;
            end
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 79) == 0);
            al = ($urandom_range(0, 1) == 0);
            am = 6'($urandom);
            step(hv, hm, hval, hnum, al, am, st, fl, rs, a);
            if (a || fl || rs) hv = 0;
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
